uart_line_buffer: RTL and testbench
===================================

# uart_line_buffer

Receive-side line assembler sitting behind `uart_rx`. It consumes the received byte stream, including break and framing-error indications, and stores bytes until a terminator character arrives. It then holds the completed line for a host or CPU-side reader, which fetches it by address and releases it with an acknowledge. It is the consumer counterpart of the string-streaming driver that feeds `uart_tx`.

## Interface
- `MaxLineLen`, 64: line storage depth in bytes, ≥ 2.
- `Terminator`, 8'h0A: end-of-line character.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse; `rx_data` is valid.
- `rx_break` in 1: one-cycle pulse; break received.
- `rx_error` in 1: one-cycle pulse; framing error on a byte.
- `line_ready` out 1: a complete line is held.
- `line_len` out LW = `$clog2(MaxLineLen+1)`: held line length, terminator excluded.
- `line_err` out 1: an `rx_error` pulse occurred during the held line.
- `rd_addr` in `$clog2(MaxLineLen)`: read address.
- `rd_data` out 8: byte at `rd_addr`, registered.
- `line_ack` in 1: releases the held line.
- `overflow` out 1: one-cycle pulse when a line exceeds `MaxLineLen`.
- `dropped` out 8: count of bytes discarded in HOLD, saturating at 255, cleared on `line_ack`.

## Operation
- **States:** COLLECT, HOLD, DISCARD. Reset state is COLLECT.
- **COLLECT, `rx_valid`:**
  - Byte == `Terminator`: latch `line_len` = `wr_ptr`, go to HOLD. The terminator is not stored.
  - Else, `wr_ptr` < `MaxLineLen`: store the byte at `wr_ptr`, then `wr_ptr`++.
  - Else (`wr_ptr` == `MaxLineLen`): pulse `overflow`, set `wr_ptr` = 0, clear the error flag, go to DISCARD.
- **Empty line:** a terminator with `wr_ptr` = 0 completes a line with `line_len` = 0.
- **COLLECT, `rx_break`:** `wr_ptr` = 0 and the error flag is cleared; the partial line is abandoned. If `rx_break` and `rx_valid` occur in the same cycle, the break wins and the byte is discarded.
- **COLLECT, `rx_error`:** sets the error flag, which is copied to `line_err` on completion.
- **DISCARD:**
  - Discards every byte until a `Terminator`, then returns to COLLECT with `wr_ptr` = 0.
  - `rx_break` also returns to COLLECT.
- **HOLD:**
  - Storage is frozen. Every `rx_valid` byte increments `dropped`, saturating.
  - `rx_break` and `rx_error` are ignored.
- **`line_ack` in HOLD:**
  - Return to COLLECT with `wr_ptr` = 0 and `line_ready`/`line_err`/`dropped` cleared.
  - An `rx_valid` in the same cycle counts as dropped and is not stored.
  - `line_ack` outside HOLD is ignored.
- **Reads:** `rd_addr` ≥ `line_len` returns stale storage contents; this is not an error.

## Timing
- **Reset values:** `line_ready`=0, `line_len`=0, `line_err`=0, `rd_data`=0, `overflow`=0, `dropped`=0, `wr_ptr`=0.
- **Line completion:** terminator `rx_valid` at cycle N → `line_ready`/`line_len`/`line_err` valid at N+1.
- **Read latency:** `rd_addr` at cycle N → `rd_data` at N+1.
  - Reading is permitted in any state.
  - The contents are stable only while `line_ready`=1.
- **`line_ack` at N:** `line_ready`=0 at N+1. A byte at N+1 is accepted into position 0.
- **Overflow:** `overflow` is high for exactly the cycle after the offending byte.
- **Reset mid-operation:** returns to COLLECT on the next edge and discards any held line.

## Configuration
- **`UART_LINE_CR_STRIP_EN` defined:**
  - In COLLECT, bytes equal to 8'h0D are discarded without storing or incrementing `wr_ptr`.
  - They never trigger overflow.
- **Not defined:** 8'h0D is stored like any other byte.

## Structure
- **Package `uart_pkg`:**
  - State enum `line_state_e` (COLLECT, HOLD, DISCARD).
  - Constants `CHAR_LF` = 8'h0A and `CHAR_CR` = 8'h0D.
- **Sub-module `uart_line_ram`:**
  - Single write port and single registered read port.
  - Depth `MaxLineLen`, 8 bits wide.
- **Control:** the FSM, pointer, and counters stay in `uart_line_buffer`.

## Test plan
- **Basic line:** stream "Hello world\n" → `line_ready`=1, `line_len`=11, `line_err`=0; `rd_addr`=0 → `rd_data`=0x48 next cycle; `rd_addr`=10 → 0x64.
- **Overflow:** `MaxLineLen`=4, "ABCDEF\n" → `overflow` pulse after 'E', no `line_ready`; then "XY\n" → `line_len`=2, data 0x58, 0x59.
- **Drops in HOLD:** hold a line, send "PQ" → `dropped`=2; `line_ack` → `dropped`=0, `line_ready`=0; then "Z\n" → `line_len`=1, byte 0x5A.
- **Break mid-line:** "AB", `rx_break` pulse, "C\n" → `line_len`=1, `rd_data`[0]=0x43.
- **Framing error:** "A", `rx_error` pulse, "B\n" → `line_len`=2, `line_err`=1; after ack, "C\n" → `line_err`=0.
- **CR stripping:** "A\r\n" → `line_len`=1 with `UART_LINE_CR_STRIP_EN` defined; `line_len`=2 and byte[1]=0x0D without it.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side line assembler.
package uart_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        HOLD,
        DISCARD
    } line_state_e;

    localparam int unsigned DATA_W  = 8;
    localparam logic [7:0]  CHAR_LF = 8'h0A;
    localparam logic [7:0]  CHAR_CR = 8'h0D;

    // Increment that sticks at the all-ones value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_line_ram.sv
// Line storage: one write port, one registered read port.
module uart_line_ram
    import uart_pkg::*;
#(
    parameter int unsigned Depth = 64,
    localparam int unsigned AW   = $clog2(Depth)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_line_buffer.sv
// Assembles received bytes into terminator-delimited lines held for a reader.
// Optional UART_LINE_CR_STRIP_EN: drop carriage returns while collecting.
module uart_line_buffer
    import uart_pkg::*;
#(
    parameter int unsigned MaxLineLen = 64,
    parameter logic [7:0]  Terminator = CHAR_LF,
    localparam int unsigned LW = $clog2(MaxLineLen + 1),
    localparam int unsigned AW = $clog2(MaxLineLen)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_break,
    input  logic          rx_error,
    output logic          line_ready,
    output logic [LW-1:0] line_len,
    output logic          line_err,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          line_ack,
    output logic          overflow,
    output logic [7:0]    dropped
);

    localparam logic [LW-1:0] MAX_PTR = LW'(MaxLineLen);

    line_state_e   state;
    logic [LW-1:0] wr_ptr;
    logic          err_flag;
    logic          is_term_c;
    logic          is_cr_c;
    logic          ram_we_c;

    assign is_term_c = (rx_data == Terminator);
`ifdef UART_LINE_CR_STRIP_EN
    assign is_cr_c = (rx_data == CHAR_CR);
`else
    assign is_cr_c = 1'b0;
`endif

    // A byte is stored only while collecting, below capacity, and not pre-empted by break.
    assign ram_we_c = (state == COLLECT) && rx_valid && !rx_break && !is_term_c
                      && !is_cr_c && (wr_ptr < MAX_PTR);

    uart_line_ram #(
        .Depth (MaxLineLen)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we_c),
        .wr_addr (AW'(wr_ptr)),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            wr_ptr     <= '0;
            err_flag   <= 1'b0;
            line_ready <= 1'b0;
            line_len   <= '0;
            line_err   <= 1'b0;
            overflow   <= 1'b0;
            dropped    <= '0;
        end else begin
            overflow <= 1'b0;
            case (state)
                COLLECT: begin
                    if (rx_break) begin
                        wr_ptr   <= '0;
                        err_flag <= 1'b0;
                    end else begin
                        if (rx_error) begin
                            err_flag <= 1'b1;
                        end
                        if (rx_valid) begin
                            if (is_term_c) begin
                                line_len   <= wr_ptr;
                                line_err   <= err_flag | rx_error;
                                line_ready <= 1'b1;
                                err_flag   <= 1'b0;
                                state      <= HOLD;
                            end else if (!is_cr_c) begin
                                if (wr_ptr < MAX_PTR) begin
                                    wr_ptr <= wr_ptr + LW'(1);
                                end else begin
                                    overflow <= 1'b1;
                                    wr_ptr   <= '0;
                                    err_flag <= 1'b0;
                                    state    <= DISCARD;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (rx_valid) begin
                        dropped <= sat_inc8(dropped);
                    end
                    // A byte arriving with the ack is still counted, against a fresh count.
                    if (line_ack) begin
                        state      <= COLLECT;
                        wr_ptr     <= '0;
                        err_flag   <= 1'b0;
                        line_ready <= 1'b0;
                        line_err   <= 1'b0;
                        dropped    <= rx_valid ? 8'd1 : 8'd0;
                    end
                end
                DISCARD: begin
                    if (rx_break || (rx_valid && is_term_c)) begin
                        state  <= COLLECT;
                        wr_ptr <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Scoreboard bench for uart_line_buffer (MaxLineLen = 16).
module tb_uart_line_buffer;

    localparam int unsigned MAX = 16;
    localparam int unsigned LW  = $clog2(MAX + 1);
    localparam int unsigned AW  = $clog2(MAX);

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_break;
    logic          rx_error;
    logic          line_ready;
    logic [LW-1:0] line_len;
    logic          line_err;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          line_ack;
    logic          overflow;
    logic [7:0]    dropped;

    uart_line_buffer #(
        .MaxLineLen (MAX),
        .Terminator (8'h0A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_break   (rx_break),
        .rx_error   (rx_error),
        .line_ready (line_ready),
        .line_len   (line_len),
        .line_err   (line_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .line_ack   (line_ack),
        .overflow   (overflow),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned len;
        bit          err;
    } line_exp_t;

    int          checks = 0;
    int          errors = 0;
    line_exp_t   line_q[$];
    logic [7:0]  rd_q[$];
    bit          ovf_q[$];
    logic        rd_req = 1'b0;
    logic        rd_req_d = 1'b0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) rd_req_d <= rd_req;

    // Monitor: pops an expectation whenever the DUT presents a line, read data or overflow.
    always @(negedge clk) begin
        line_exp_t  e;
        logic [7:0] d;
        if (line_ready && !prev_ready) begin
            checks++;
            if (line_q.size() == 0) begin
                errors++;
                $display("FAIL line_unexpected: got len=%0d err=%0b, none expected", line_len, line_err);
            end else begin
                e = line_q.pop_front();
                if (line_len !== LW'(e.len) || line_err !== e.err) begin
                    errors++;
                    $display("FAIL line: got len=%0d err=%0b, want len=%0d err=%0b",
                             line_len, line_err, e.len, e.err);
                end
            end
        end
        prev_ready = line_ready;
        if (rd_req_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %02h", rd_data);
            end else begin
                d = rd_q.pop_front();
                if (rd_data !== d) begin
                    errors++;
                    $display("FAIL rd_data: got %02h want %02h", rd_data, d);
                end
            end
        end
        if (overflow) begin
            checks++;
            if (ovf_q.size() == 0) begin
                errors++;
                $display("FAIL overflow_unexpected: got 1 want 0");
            end else begin
                void'(ovf_q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    endtask

    task automatic expect_line(input int unsigned len, input bit err);
        line_exp_t e;
        e.len = len;
        e.err = err;
        line_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!line_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!line_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got line_ready=0 want 1");
        end
        cyc();
    endtask

    task automatic read_chk(input int unsigned addr, input logic [7:0] exp);
        rd_addr = AW'(addr);
        rd_q.push_back(exp);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic ack();
        line_ack = 1'b1;
        cyc();
        line_ack = 1'b0;
        chk("ready_after_ack", 32'(line_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_break = 1'b0;
        rx_error = 1'b0; rd_addr = '0; line_ack = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_line_ready", 32'(line_ready), 32'd0);
        chk("rst_line_len",   32'(line_len),   32'd0);
        chk("rst_line_err",   32'(line_err),   32'd0);
        chk("rst_rd_data",    32'(rd_data),    32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        chk("rst_dropped",    32'(dropped),    32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Basic line
        expect_line(11, 1'b0);
        send_str("Hello world\n");
        wait_ready();
        read_chk(0, 8'h48);
        read_chk(10, 8'h64);
        read_chk(4, 8'h6F);
        ack();

        // Drops in HOLD, errors/breaks ignored in HOLD, byte right after ack lands at 0
        expect_line(2, 1'b0);
        send_str("Hi\n");
        wait_ready();
        send_str("PQ");
        rx_error = 1'b1; rx_break = 1'b1; cyc(); rx_error = 1'b0; rx_break = 1'b0;
        chk("dropped_2", 32'(dropped), 32'd2);
        chk("len_frozen", 32'(line_len), 32'd2);
        read_chk(1, 8'h69);
        ack();
        chk("dropped_cleared", 32'(dropped), 32'd0);
        expect_line(1, 1'b0);
        send_str("Z\n");
        wait_ready();
        read_chk(0, 8'h5A);
        for (int i = 0; i < 260; i++) send_byte(8'h41);
        chk("dropped_sat", 32'(dropped), 32'd255);
        ack();

        // Break mid-line, break wins over a simultaneous byte
        send_str("AB");
        rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h51;
        cyc();
        rx_break = 1'b0; rx_valid = 1'b0;
        expect_line(1, 1'b0);
        send_str("C\n");
        wait_ready();
        read_chk(0, 8'h43);
        ack();

        // Framing error flagged, then cleared for the next line
        send_str("A");
        rx_error = 1'b1; cyc(); rx_error = 1'b0;
        expect_line(2, 1'b1);
        send_str("B\n");
        wait_ready();
        ack();
        expect_line(1, 1'b0);
        send_str("C\n");
        wait_ready();
        ack();

        // Exactly full line fits
        expect_line(16, 1'b0);
        send_str("0123456789abcdef\n");
        wait_ready();
        read_chk(15, 8'h66);
        ack();

        // One byte too many: overflow, discard to terminator
        send_str("0123456789abcdef");
        ovf_q.push_back(1'b1);
        send_str("g");
        send_str("hi\n");
        expect_line(2, 1'b0);
        send_str("XY\n");
        wait_ready();
        read_chk(0, 8'h58);
        read_chk(1, 8'h59);
        ack();

        // Break leaves DISCARD
        send_str("0123456789abcdef");
        ovf_q.push_back(1'b1);
        send_str("gh");
        rx_break = 1'b1; cyc(); rx_break = 1'b0;
        expect_line(1, 1'b0);
        send_str("W\n");
        wait_ready();
        read_chk(0, 8'h57);
        ack();

        // Empty line
        expect_line(0, 1'b0);
        send_str("\n");
        wait_ready();
        ack();

        // Carriage return handling
`ifdef UART_LINE_CR_STRIP_EN
        expect_line(1, 1'b0);
        send_str("A\r\n");
        wait_ready();
        read_chk(0, 8'h41);
`else
        expect_line(2, 1'b0);
        send_str("A\r\n");
        wait_ready();
        read_chk(1, 8'h0D);
`endif
        ack();

        // Reset while holding a line
        expect_line(2, 1'b0);
        send_str("MN\n");
        wait_ready();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("ready_after_rst", 32'(line_ready), 32'd0);
        expect_line(1, 1'b0);
        send_str("R\n");
        wait_ready();
        read_chk(0, 8'h52);
        ack();

        repeat (3) cyc();
        chk("line_q_empty", 32'(line_q.size()), 32'd0);
        chk("rd_q_empty",   32'(rd_q.size()),   32'd0);
        chk("ovf_q_empty",  32'(ovf_q.size()),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
